// File: rtl/bit_select.sv
// -----------------------------------------------------------------------------
// bit_select
//   Select unit: given a DATA_WIDTH-bit vector and a 0-based rank k, returns the
//   bit index of the (k+1)-th set bit counting from the LSB. It is the inverse of
//   the popcount path and works on the same wide words. One CHUNK_WIDTH slice is
//   popcounted per cycle. Once the chunk holding the target bit is known, one
//   further cycle locates the bit inside that chunk.
//
//   Ports
//     clk        clock, all logic on posedge
//     rst        synchronous reset, active-high; aborts any request in flight
//     in_valid   request valid
//     in_ready   request accepted when in_valid && in_ready (IDLE only)
//     in_vec     vector to search (captured on accept)
//     in_rank    0-based rank k (captured on accept)
//     out_valid  result valid, held until out_ready
//     out_ready  result consumed when out_valid && out_ready
//     out_found  1 when k < popcount(in_vec)
//     out_index  index of the selected bit, 0 when out_found = 0
// -----------------------------------------------------------------------------
module bit_select #(
  parameter  int DATA_WIDTH  = 1024,
  parameter  int CHUNK_WIDTH = 64,
  localparam int IDX_W       = $clog2(DATA_WIDTH),
  localparam int RANK_W      = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec,
  input  logic [RANK_W-1:0]     in_rank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_found,
  output logic [IDX_W-1:0]      out_index
);

  localparam int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CHUNK_IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CNT_W       = $clog2(CHUNK_WIDTH + 1);
  localparam int POS_W       = (CHUNK_WIDTH > 1) ? $clog2(CHUNK_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LOCATE,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   vec_q;
  logic [RANK_W-1:0]       rem_q;     // rank still to skip, relative to chunk_q
  logic [CHUNK_IDX_W-1:0]  chunk_q;
  logic                    found_q;
  logic [IDX_W-1:0]        index_q;

  logic [CHUNK_WIDTH-1:0]  chunk_bits;
  logic [CNT_W-1:0]        chunk_cnt;
  logic                    hit;
  logic                    last_chunk;

  logic [CNT_W-1:0]        loc_seen;
  logic [POS_W-1:0]        loc_pos;
  logic                    loc_done;
  logic [IDX_W-1:0]        loc_index;

  assign chunk_bits = vec_q[chunk_q*CHUNK_WIDTH +: CHUNK_WIDTH];

  // Popcount of the current chunk.
  // NOTE: combinational accumulators use blocking '=' so each loop iteration
  // sees the previous partial sum; registers below use non-blocking '<='.
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_cnt = chunk_cnt + CNT_W'(chunk_bits[i]);
    end
  end

  // The target lies in this chunk when fewer than chunk_cnt ranks remain.
  assign hit        = rem_q < RANK_W'(chunk_cnt);
  assign last_chunk = chunk_q == CHUNK_IDX_W'(NUM_CHUNKS - 1);

  // Position of the (rem+1)-th set bit inside the chunk. Only meaningful in
  // LOCATE, where rem_q < chunk_cnt <= CHUNK_WIDTH, so its low CNT_W bits
  // hold the full value.
  always_comb begin
    loc_seen = '0;
    loc_pos  = '0;
    loc_done = 1'b0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (chunk_bits[i]) begin
        if (!loc_done && (loc_seen == rem_q[CNT_W-1:0])) begin
          loc_pos  = POS_W'(i);
          loc_done = 1'b1;
        end
        loc_seen = loc_seen + CNT_W'(1);
      end
    end
  end

  assign loc_index = IDX_W'(chunk_q * CHUNK_WIDTH) + IDX_W'(loc_pos);

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SCAN;
      SCAN: begin
        if (hit)             state_d = LOCATE;
        else if (last_chunk) state_d = DONE;
      end
      LOCATE:  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: vec_q is a plain register, not a memory array, so clearing it on
  // reset is cheap and keeps a stale query from surviving an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      found_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q   <= in_vec;
            rem_q   <= in_rank;
            chunk_q <= '0;
            found_q <= 1'b0;
            index_q <= '0;
          end
        end
        SCAN: begin
          if (!hit) begin
            if (last_chunk) begin
              // Rank exceeds popcount: the miss is reported only after all chunks are scanned.
              found_q <= 1'b0;
              index_q <= '0;
            end else begin
              rem_q   <= rem_q - RANK_W'(chunk_cnt);
              chunk_q <= chunk_q + CHUNK_IDX_W'(1);
            end
          end
        end
        LOCATE: begin
          found_q <= 1'b1;
          index_q <= loc_index;
        end
        default: ;
      endcase
    end
  end

  // in_ready depends on state and rst only, never on in_valid.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_found = found_q;
  assign out_index = index_q;

endmodule

// File: tb/tb_bit_select.sv
// -----------------------------------------------------------------------------
// tb_bit_select
//   Directed bench for bit_select. A reference model computes the expected
//   found/index/latency by scanning the vector bit by bit. Literal expectations
//   pin the model, and a compare process checks the DUT on every cycle that
//   out_valid is high.
// -----------------------------------------------------------------------------
module tb_bit_select;

  localparam int DW     = 1024;
  localparam int CW     = 64;
  localparam int NC     = DW / CW;
  localparam int IDX_W  = $clog2(DW);
  localparam int RANK_W = IDX_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_vec;
  logic [RANK_W-1:0] in_rank;
  logic              out_valid;
  logic              out_ready;
  logic              out_found;
  logic [IDX_W-1:0]  out_index;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard for the request in flight.
  bit exp_pending = 1'b0;
  bit exp_found   = 1'b0;
  int exp_index   = 0;

  bit_select #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_rank   (in_rank),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_found (out_found),
    .out_index (out_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the bits from the LSB. Latency is the hit chunk + 2, or
  // NC for a miss.
  task automatic model(input logic [DW-1:0] v, input int k,
                       output bit found, output int idx, output int lat);
    int seen;
    seen  = 0;
    found = 1'b0;
    idx   = 0;
    lat   = NC;
    for (int i = 0; i < DW; i++) begin
      if (v[i]) begin
        if (!found && seen == k) begin
          found = 1'b1;
          idx   = i;
          lat   = i / CW + 2;
        end
        seen++;
      end
    end
  endtask

  // Compare process: the result must match the model whenever it is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_pending) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        check("out_found", out_found, exp_found);
        check("out_index", out_index, exp_index);
        check("in_ready_in_done", in_ready, 1'b0);
      end
    end
  end

  task automatic scramble_inputs();
    for (int i = 0; i < DW / 32; i++) in_vec[i*32 +: 32] = $urandom;
    in_rank = RANK_W'($urandom);
  endtask

  // Wait until the DUT can accept. Inputs are driven 1 time unit after posedge.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  // One full request. hold > 0 keeps out_ready low for that many cycles in
  // DONE. With poke set, in_valid is driven during the hold to confirm the
  // extra request is dropped.
  task automatic do_req(input string name, input logic [DW-1:0] v, input int k,
                        input bit lit_found, input int lit_index, input int lit_lat,
                        input int hold, input bit poke);
    bit mf;
    int mi, ml, n;
    model(v, k, mf, mi, ml);
    check({name, "_model_found"}, mf, lit_found);
    check({name, "_model_index"}, mi, lit_index);
    check({name, "_model_lat"},   ml, lit_lat);

    wait_ready(name);
    exp_found   = mf;
    exp_index   = mi;
    exp_pending = 1'b1;
    in_valid    = 1'b1;
    in_vec      = v;
    in_rank     = RANK_W'(k);
    out_ready   = (hold == 0);
    @(posedge clk); #1;            // accept edge E0
    in_valid = 1'b0;
    scramble_inputs();             // inputs need not be held after accept

    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, ml);

    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_vec   = ~v;
        in_rank  = '0;
      end
      @(posedge clk); #1;
      check({name, "_held_valid"}, out_valid, 1'b1);
      check({name, "_held_found"}, out_found, mf);
      check({name, "_held_index"}, out_index, mi);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;            // handshake edge
    exp_pending = 1'b0;
    out_ready   = 1'b0;
    check({name, "_valid_drop"}, out_valid, 1'b0);
    check({name, "_idle_ready"}, in_ready, 1'b1);
  endtask

  logic [DW-1:0] v;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    in_rank   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_found", out_found, 1'b0);
    check("rst_out_index", out_index, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // T1: lowest bit
    v = '0; v[0] = 1'b1;
    do_req("t1", v, 0, 1'b1, 0, 2, 0, 1'b0);

    // T2: top bit, last chunk
    v = '0; v[DW-1] = 1'b1;
    do_req("t2", v, 0, 1'b1, 1023, 17, 0, 1'b0);

    // T3: all ones
    v = '1;
    do_req("t3_k700",  v, 700,  1'b1, 700,  12, 0, 1'b0);
    do_req("t3_k1023", v, 1023, 1'b1, 1023, 17, 0, 1'b0);
    do_req("t3_k1024", v, 1024, 1'b0, 0,    16, 0, 1'b0);

    // T4: sparse bits {3,64,200,511,1000}
    v = '0; v[3] = 1'b1; v[64] = 1'b1; v[200] = 1'b1; v[511] = 1'b1; v[1000] = 1'b1;
    do_req("t4_k0", v, 0, 1'b1, 3,    2,  0, 1'b0);
    do_req("t4_k3", v, 3, 1'b1, 511,  9,  0, 1'b0);
    do_req("t4_k4", v, 4, 1'b1, 1000, 17, 0, 1'b0);
    do_req("t4_k5", v, 5, 1'b0, 0,    16, 0, 1'b0);

    // Odd bits: the rank carries across the chunk 0/1 boundary.
    v = '0;
    for (int i = 1; i < DW; i += 2) v[i] = 1'b1;
    do_req("odd_k31", v, 31, 1'b1, 63, 2, 0, 1'b0);
    do_req("odd_k32", v, 32, 1'b1, 65, 3, 0, 1'b0);

    // T5: back-pressure in DONE with a competing request driven
    v = '0; v[3] = 1'b1; v[64] = 1'b1; v[200] = 1'b1; v[511] = 1'b1; v[1000] = 1'b1;
    do_req("t5", v, 1, 1'b1, 64, 3, 10, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      check("t5_dropped", out_valid, 1'b0);
    end

    // T6: reset mid-SCAN aborts without a result
    v = '0; v[DW-1] = 1'b1;
    wait_ready("t6");
    exp_pending = 1'b1;
    in_valid    = 1'b1;
    in_vec      = v;
    in_rank     = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst         = 1'b1;
    exp_pending = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_out_found", out_found, 1'b0);
    check("t6_out_index", out_index, 0);
    check("t6_in_ready",  in_ready,  1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_result", out_valid, 1'b0);
    v = '0; v[0] = 1'b1;
    do_req("t6_t1", v, 0, 1'b1, 0, 2, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
